// File: rtl/lvds_rx_align_ctrl.sv
// ============================================================================
// Module      : lvds_rx_align_ctrl
// Description : LVDS RX alignment sequencer. It requests PHY alignment, waits
//               for all lanes to report aligned, checks that they stay aligned,
//               then monitors for lock loss. The retry count is bounded.
//               Optional macro LVDS_ALIGN_LOSS_CNT_EN adds a lock-loss counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lvds_rx_align_ctrl #(
    parameter int C_LANE_NUM       = 2,
    parameter int C_REQ_CYCLES     = 4,
    parameter int C_TIMEOUT_CYCLES = 4096,
    parameter int C_STABLE_CYCLES  = 64,
    parameter int C_MAX_RETRY      = 8
) (
    input  logic                  CLKDIV_I,
    input  logic                  RSTN_I,
    input  logic                  START_I,
    input  logic [C_LANE_NUM-1:0] BIT_ALIGN_I,
    input  logic [C_LANE_NUM-1:0] BYTE_ALIGN_I,
    output logic                  INIT_REQ_O,
    output logic                  LOCKED_O,
    output logic                  FAIL_O,
    output logic                  BUSY_O,
    output logic [3:0]            RETRY_CNT_O,
    output logic [2:0]            STATE_O,
    output logic [15:0]           LOSS_CNT_O
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_VERIFY = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;

    localparam logic [15:0] C_REQ_LAST   = 16'(C_REQ_CYCLES - 1);
    localparam logic [15:0] C_TMO_LAST   = 16'(C_TIMEOUT_CYCLES - 1);
    localparam logic [15:0] C_STB_LAST   = 16'(C_STABLE_CYCLES - 1);
    localparam logic [3:0]  C_RETRY_LAST = 4'(C_MAX_RETRY - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        all_ok;

    assign all_ok = (&BIT_ALIGN_I) & (&BYTE_ALIGN_I);

    // cnt_q is shared by REQ, WAIT and VERIFY; every state change clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        retry_d = retry_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (START_I) begin
                    retry_d = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cnt_q == C_REQ_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT, ST_VERIFY: begin
                if (state_q == ST_WAIT ? all_ok : (all_ok && cnt_q == C_STB_LAST)) begin
                    cnt_d   = '0;
                    state_d = (state_q == ST_WAIT) ? ST_VERIFY : ST_LOCKED;
                end else if (state_q == ST_WAIT ? (cnt_q == C_TMO_LAST) : !all_ok) begin
                    cnt_d = '0;
                    if (retry_q == C_RETRY_LAST) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_LOCKED: begin
                cnt_d = '0;
                if (!all_ok || START_I) begin
                    retry_d = '0;
                    state_d = ST_REQ;
                end
            end
            ST_FAIL: begin
                cnt_d = '0;
                if (START_I) begin
                    retry_d = '0;
                    state_d = ST_REQ;
                end
            end
            default: begin
                cnt_d   = '0;
                retry_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state so they track STATE_O exactly.
    always_ff @(posedge CLKDIV_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            retry_q    <= '0;
            INIT_REQ_O <= 1'b0;
            LOCKED_O   <= 1'b0;
            FAIL_O     <= 1'b0;
            BUSY_O     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            INIT_REQ_O <= (state_d == ST_REQ);
            LOCKED_O   <= (state_d == ST_LOCKED);
            FAIL_O     <= (state_d == ST_FAIL);
            BUSY_O     <= (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_VERIFY);
        end
    end

    assign STATE_O     = state_q;
    assign RETRY_CNT_O = retry_q;

`ifdef LVDS_ALIGN_LOSS_CNT_EN
    logic [15:0] loss_q;
    logic        loss_inc;

    assign loss_inc = (state_q == ST_LOCKED) && !all_ok;

    always_ff @(posedge CLKDIV_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            loss_q <= '0;
        end else if (loss_inc && (loss_q != 16'hFFFF)) begin
            loss_q <= loss_q + 16'd1;
        end
    end

    assign LOSS_CNT_O = loss_q;
`else
    assign LOSS_CNT_O = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lvds_rx_align_ctrl.sv
// ============================================================================
// Module      : tb_lvds_rx_align_ctrl
// Description : Directed self-checking bench for lvds_rx_align_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lvds_rx_align_ctrl;

    localparam int C_LANE_NUM       = 2;
    localparam int C_REQ_CYCLES     = 4;
    localparam int C_TIMEOUT_CYCLES = 32;
    localparam int C_STABLE_CYCLES  = 8;
    localparam int C_MAX_RETRY      = 3;

`ifdef LVDS_ALIGN_LOSS_CNT_EN
    localparam logic [15:0] EXP_LOSS = 16'd1;
`else
    localparam logic [15:0] EXP_LOSS = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  bit_al = 2'b00;
    logic [1:0]  byte_al = 2'b00;
    logic        init_req, locked, fail, busy;
    logic [3:0]  retry_cnt;
    logic [2:0]  state;
    logic [15:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lvds_rx_align_ctrl #(
        .C_LANE_NUM      (C_LANE_NUM),
        .C_REQ_CYCLES    (C_REQ_CYCLES),
        .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES),
        .C_STABLE_CYCLES (C_STABLE_CYCLES),
        .C_MAX_RETRY     (C_MAX_RETRY)
    ) dut (
        .CLKDIV_I    (clk),
        .RSTN_I      (rstn),
        .START_I     (start),
        .BIT_ALIGN_I (bit_al),
        .BYTE_ALIGN_I(byte_al),
        .INIT_REQ_O  (init_req),
        .LOCKED_O    (locked),
        .FAIL_O      (fail),
        .BUSY_O      (busy),
        .RETRY_CNT_O (retry_cnt),
        .STATE_O     (state),
        .LOSS_CNT_O  (loss_cnt)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; start = 1'b0; bit_al = 2'b00; byte_al = 2'b00;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if ({init_req, locked, fail, busy, retry_cnt, state, loss_cnt} !== 27'd0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", {init_req, locked, fail, busy, retry_cnt, state, loss_cnt});
        end
        rstn = 1'b1;
        tick(3);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_idle_hold: state %0d required 0", state); end
    endtask

    task automatic test_happy_path();
        int n;
        pulse_start();
        checks++;
        if (state !== 3'd1 || init_req !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL happy_enter_req: state %0d init %b busy %b required 1 1 1", state, init_req, busy);
        end
        n = 0;
        for (int k = 0; k < 20 && init_req === 1'b1; k++) begin n++; tick(1); end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL happy_req_len: got %0d required 4", n); end
        tick(9);
        bit_al = 2'b11; byte_al = 2'b11;
        tick(1);
        checks++;
        if (state !== 3'd3) begin errors++; $display("FAIL happy_verify: state %0d required 3", state); end
        tick(7);
        checks++;
        if (state !== 3'd3 || locked !== 1'b0) begin
            errors++; $display("FAIL happy_verify_7: state %0d locked %b required 3 0", state, locked);
        end
        tick(1);
        checks++;
        if (state !== 3'd4 || locked !== 1'b1 || retry_cnt !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL happy_locked: state %0d locked %b retry %0d busy %b required 4 1 0 0", state, locked, retry_cnt, busy);
        end
    endtask

    task automatic test_lock_loss();
        bit_al[0] = 1'b0;
        tick(1);
        bit_al[0] = 1'b1;
        checks++;
        if (state !== 3'd1 || locked !== 1'b0 || retry_cnt !== 4'd0) begin
            errors++; $display("FAIL loss_req: state %0d locked %b retry %0d required 1 0 0", state, locked, retry_cnt);
        end
        checks++;
        if (loss_cnt !== EXP_LOSS) begin errors++; $display("FAIL loss_count: got %0d required %0d", loss_cnt, EXP_LOSS); end
        for (int k = 0; k < 200 && locked !== 1'b1; k++) tick(1);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL loss_relock: locked %b required 1", locked); end
        pulse_start();
        checks++;
        if (state !== 3'd1 || loss_cnt !== EXP_LOSS) begin
            errors++; $display("FAIL locked_restart: state %0d loss %0d required 1 %0d", state, loss_cnt, EXP_LOSS);
        end
    endtask

    task automatic test_timeout_fail();
        int rise[4];
        int rr[4];
        int np, cyc;
        logic prev;
        do_reset();
        pulse_start();
        np = 0; cyc = 0; prev = 1'b0;
        for (int k = 0; k < 300 && fail !== 1'b1; k++) begin
            if (init_req === 1'b1 && prev === 1'b0 && np < 4) begin
                rise[np] = cyc; rr[np] = retry_cnt; np++;
            end
            start = (k == 20);
            prev = init_req;
            tick(1);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (np !== 3) begin
            errors++; $display("FAIL tmo_pulses: got %0d required 3", np);
        end else begin
            checks++;
            if (rise[1] - rise[0] !== 36 || rise[2] - rise[1] !== 36) begin
                errors++; $display("FAIL tmo_spacing: got %0d %0d required 36 36", rise[1] - rise[0], rise[2] - rise[1]);
            end
            checks++;
            if (rr[0] !== 0 || rr[1] !== 1 || rr[2] !== 2) begin
                errors++; $display("FAIL tmo_retry_steps: got %0d %0d %0d required 0 1 2", rr[0], rr[1], rr[2]);
            end
            checks++;
            if (cyc - rise[2] !== 36) begin errors++; $display("FAIL tmo_fail_time: got %0d required 36", cyc - rise[2]); end
        end
        checks++;
        if (fail !== 1'b1 || state !== 3'd5 || retry_cnt !== 4'd2 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_fail_state: fail %b state %0d retry %0d busy %b required 1 5 2 0", fail, state, retry_cnt, busy);
        end
        tick(5);
        checks++;
        if (fail !== 1'b1) begin errors++; $display("FAIL tmo_fail_hold: got %b required 1", fail); end
        pulse_start();
        checks++;
        if (state !== 3'd1 || retry_cnt !== 4'd0 || fail !== 1'b0 || init_req !== 1'b1) begin
            errors++; $display("FAIL tmo_restart: state %0d retry %0d fail %b init %b required 1 0 0 1", state, retry_cnt, fail, init_req);
        end
    endtask

    task automatic test_verify_glitch();
        do_reset();
        bit_al = 2'b11; byte_al = 2'b11;
        pulse_start();
        for (int k = 0; k < 50 && state !== 3'd3; k++) tick(1);
        checks++;
        if (state !== 3'd3) begin errors++; $display("FAIL glitch_verify: state %0d required 3", state); end
        tick(4);
        byte_al[1] = 1'b0;
        tick(1);
        byte_al[1] = 1'b1;
        checks++;
        if (state !== 3'd1 || retry_cnt !== 4'd1 || init_req !== 1'b1) begin
            errors++; $display("FAIL glitch_retry: state %0d retry %0d init %b required 1 1 1", state, retry_cnt, init_req);
        end
        for (int k = 0; k < 100 && locked !== 1'b1; k++) tick(1);
        checks++;
        if (locked !== 1'b1 || state !== 3'd4 || retry_cnt !== 4'd1) begin
            errors++; $display("FAIL glitch_relock: locked %b state %0d retry %0d required 1 4 1", locked, state, retry_cnt);
        end
    endtask

    task automatic test_timeout_boundary();
        do_reset();
        pulse_start();
        for (int k = 0; k < 50 && state !== 3'd2; k++) tick(1);
        tick(31);
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL bound_wait: state %0d required 2", state); end
        bit_al = 2'b11; byte_al = 2'b11;
        tick(1);
        checks++;
        if (state !== 3'd3 || retry_cnt !== 4'd0 || init_req !== 1'b0) begin
            errors++; $display("FAIL bound_verify: state %0d retry %0d init %b required 3 0 0", state, retry_cnt, init_req);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_start();
        tick(1);
        checks++;
        if (init_req !== 1'b1) begin errors++; $display("FAIL areset_pre: init %b required 1", init_req); end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({init_req, locked, fail, busy, retry_cnt, state, loss_cnt} !== 27'd0) begin
            errors++; $display("FAIL areset_outputs: got %h required 0", {init_req, locked, fail, busy, retry_cnt, state, loss_cnt});
        end
        tick(1);
        rstn = 1'b1;
        tick(3);
        checks++;
        if (state !== 3'd0 || init_req !== 1'b0) begin
            errors++; $display("FAIL areset_idle: state %0d init %b required 0 0", state, init_req);
        end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_lock_loss();
        test_timeout_fail();
        test_verify_glitch();
        test_timeout_boundary();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/lvds_rx_align_ctrl.md
LVDS_RX_ALIGN_CTRL -- requirements
Module: lvds_rx_align_ctrl

Interface
REQ-001 Parameter C_LANE_NUM, default 2, SHALL set the number of RX lanes monitored.
REQ-002 Parameter C_REQ_CYCLES, default 4, SHALL set the INIT_REQ_O pulse length in cycles (legal range 1-255).
REQ-003 Parameter C_TIMEOUT_CYCLES, default 4096, SHALL set the alignment wait timeout in cycles (legal range 2-65535).
REQ-004 Parameter C_STABLE_CYCLES, default 64, SHALL set the consecutive all-aligned cycles required for lock (legal range 1-65535).
REQ-005 Parameter C_MAX_RETRY, default 8, SHALL set the number of alignment attempts before failure (legal range 1-15).
REQ-006 The clock and reset SHALL be as follows: one clock; reset is asynchronous and active-low.
REQ-007 CLKDIV_I  in  1  SHALL be the parallel-side clock; all logic is on its rising edge.
REQ-008 RSTN_I  in  1  SHALL be the asynchronous, active-low reset.
REQ-009 START_I  in  1  SHALL be a one-cycle start/restart request.
REQ-010 BIT_ALIGN_I  in  C_LANE_NUM  SHALL carry the per-lane bit-aligned flags, synchronous to CLKDIV_I.
REQ-011 BYTE_ALIGN_I  in  C_LANE_NUM  SHALL carry the per-lane byte-aligned flags, synchronous to CLKDIV_I.
REQ-012 INIT_REQ_O  out  1  SHALL be the alignment request to the LVDS RX PHY.
REQ-013 LOCKED_O  out  1  SHALL indicate that all lanes are locked.
REQ-014 FAIL_O  out  1  SHALL indicate that the retry budget is exhausted.
REQ-015 BUSY_O  out  1  SHALL be high in states REQ, WAIT and VERIFY.
REQ-016 RETRY_CNT_O  out  4  SHALL carry the count of failed attempts in the current sequence.
REQ-017 STATE_O  out  3  SHALL carry the state code: IDLE=0, REQ=1, WAIT=2, VERIFY=3, LOCKED=4, FAIL=5.
REQ-018 LOSS_CNT_O  out  16  SHALL carry the lock-loss count (see Configuration).

Function
REQ-019 The block SHALL treat "all_ok" as the AND of every bit of BIT_ALIGN_I and BYTE_ALIGN_I.
REQ-020 All outputs SHALL be registered; each output SHALL reflect the state entered on the same edge.
REQ-021 In IDLE, START_I=1 SHALL clear the retry count and enter REQ; otherwise IDLE SHALL hold.
REQ-022 In REQ, INIT_REQ_O SHALL be 1 for exactly C_REQ_CYCLES cycles, after which the state SHALL become WAIT with the timer cleared.
REQ-023 In WAIT, all_ok=1 SHALL enter VERIFY; otherwise, when the timer reaches C_TIMEOUT_CYCLES-1, the retry rule SHALL apply; if both occur in the same cycle, all_ok SHALL win.
REQ-024 In VERIFY, C_STABLE_CYCLES consecutive cycles with all_ok=1 SHALL enter LOCKED; any cycle with all_ok=0 SHALL apply the retry rule.
REQ-025 Retry rule: if RETRY_CNT_O equals C_MAX_RETRY-1, the state SHALL become FAIL; otherwise RETRY_CNT_O SHALL increment and the state SHALL become REQ.
REQ-026 In LOCKED, all_ok=0 SHALL clear the retry count, increment the loss count and enter REQ.
REQ-027 In LOCKED, START_I=1 with all_ok=1 SHALL enter REQ without counting a loss.
REQ-028 In FAIL, FAIL_O SHALL hold at 1 until START_I=1, which SHALL clear the retry count and enter REQ.
REQ-029 START_I SHALL be ignored in REQ, WAIT and VERIFY.
REQ-030 Illegal state codes SHALL return the FSM to IDLE on the next edge.

Reset
REQ-031 While RSTN_I=0, the state SHALL be IDLE and all counters and outputs SHALL be 0, including LOSS_CNT_O.
REQ-032 Reset asserted mid-sequence SHALL abort immediately, with INIT_REQ_O dropping asynchronously.
REQ-033 After RSTN_I deasserts, the block SHALL remain in IDLE until START_I.

Configuration
REQ-034 With macro LVDS_ALIGN_LOSS_CNT_EN defined, LOSS_CNT_O SHALL be a 16-bit counter that saturates at 0xFFFF and increments per REQ-026.
REQ-035 Without LVDS_ALIGN_LOSS_CNT_EN, LOSS_CNT_O SHALL be tied to 0 and no counter logic SHALL be synthesized.

Verification (C_LANE_NUM=2, C_REQ_CYCLES=4, C_TIMEOUT_CYCLES=32, C_STABLE_CYCLES=8, C_MAX_RETRY=3)
REQ-036 Happy path: START_I pulse, then align flags 2'b11 raised 10 cycles after INIT_REQ_O falls -> INIT_REQ_O high exactly 4 cycles; LOCKED_O=1 eight cycles after entering VERIFY; RETRY_CNT_O=0.
REQ-037 Timeout to fail: flags held at 0 -> three INIT_REQ_O pulses spaced 4+32 cycles; RETRY_CNT_O steps 0,1,2; FAIL_O=1 and STATE_O=5; a later START_I returns the FSM to REQ with RETRY_CNT_O=0.
REQ-038 VERIFY glitch: BYTE_ALIGN_I[1] drops for one cycle at VERIFY cycle 5 -> RETRY_CNT_O=1 and a new REQ; a clean second attempt locks.
REQ-039 Lock loss: in LOCKED, drop BIT_ALIGN_I[0] -> STATE_O=1 next cycle; LOSS_CNT_O=1 with LVDS_ALIGN_LOSS_CNT_EN, 0 without it.
REQ-040 Boundary and reset: all_ok rises in the same cycle the timer reaches 31 -> VERIFY, not a retry; RSTN_I=0 during REQ -> INIT_REQ_O=0 asynchronously and all outputs 0.
